// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM arbiter.
// - cmd_e   : controller command encoding (IDLE/WRITE/READ, value 3 unused)
// - state_e : arbiter transaction state
// - cmd_of  : maps a latched write flag to the command to drive
package sdram_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  function automatic cmd_e cmd_of(input logic is_write);
    return is_write ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Two-requester round-robin grant selection.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   req_i      : request vector, bit p = requester p
//   accept_i   : high when the current grant is actually taken
//   grant_o    : one-hot grant (all zero when nobody requests)
// The requester holding priority wins a tie; once a grant is accepted the
// other requester gets priority. Requester 0 holds priority after reset.
module round_robin_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    grant_o = 2'b00;
    if (prio_q == 1'b0) begin
      if (req_i[0])      grant_o = 2'b01;
      else if (req_i[1]) grant_o = 2'b10;
    end else begin
      if (req_i[1])      grant_o = 2'b10;
      else if (req_i[0]) grant_o = 2'b01;
    end
  end

  // Granting requester 0 hands priority to 1 and vice versa.
  always_comb begin
    prio_d = prio_q;
    if (accept_i && (|grant_o)) prio_d = grant_o[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client arbiter in front of a single-outstanding SDRAM controller.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   req_*_0 / req_*_1          : client request channels (valid/ready)
//   resp_*_0 / resp_*_1        : one-cycle response pulses per client
//   command, data_address,
//   data_write                 : controller command and operands
//   data_read, data_read_valid,
//   data_write_done            : controller completion inputs
// One request is granted at a time; the controller command is held until
// the matching completion strobe or the watchdog expires, followed by a
// single idle GAP cycle before the next grant.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 22,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid_0,
  output logic                     req_ready_0,
  input  logic                     req_write_0,
  input  logic [ADDRESS_WIDTH-1:0] req_address_0,
  input  logic [DATA_WIDTH-1:0]    req_data_0,
  input  logic                     req_valid_1,
  output logic                     req_ready_1,
  input  logic                     req_write_1,
  input  logic [ADDRESS_WIDTH-1:0] req_address_1,
  input  logic [DATA_WIDTH-1:0]    req_data_1,
  output logic                     resp_valid_0,
  output logic [DATA_WIDTH-1:0]    resp_data_0,
  output logic                     resp_error_0,
  output logic                     resp_valid_1,
  output logic [DATA_WIDTH-1:0]    resp_data_1,
  output logic                     resp_error_1,
  output logic [1:0]               command,
  output logic [ADDRESS_WIDTH-1:0] data_address,
  output logic [DATA_WIDTH-1:0]    data_write,
  input  logic [DATA_WIDTH-1:0]    data_read,
  input  logic                     data_read_valid,
  input  logic                     data_write_done
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               resp_valid_q, resp_valid_d;
  logic [1:0]               resp_error_q, resp_error_d;
  logic [DATA_WIDTH-1:0]    resp_data_q [2];
  logic [DATA_WIDTH-1:0]    resp_data_d [2];

  logic [1:0]               req_vec;
  logic [1:0]               req_write;
  logic [ADDRESS_WIDTH-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0]    req_data [2];
  logic [1:0]               grant;
  logic                     accept;
  logic                     sel;
  logic                     complete;
  logic                     finish;
  logic                     timed_out;

  assign req_vec     = {req_valid_1, req_valid_0};
  assign req_write   = {req_write_1, req_write_0};
  assign req_addr[0] = req_address_0;
  assign req_addr[1] = req_address_1;
  assign req_data[0] = req_data_0;
  assign req_data[1] = req_data_1;

  // Reset also masks ready so no handshake can appear while it is held.
  assign accept = (state_q == ST_IDLE) && (|req_vec) && !reset;
  assign sel    = grant[1];

  assign req_ready_0 = accept && grant[0];
  assign req_ready_1 = accept && grant[1];

  round_robin_arbiter u_rr (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_vec),
    .accept_i (accept),
    .grant_o  (grant)
  );

  // Only the strobe matching the latched transaction type counts.
  assign complete = write_q ? data_write_done : data_read_valid;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = sel;
          write_d = req_write[sel];
          addr_d  = req_addr[sel];
          wdata_d = req_data[sel];
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (complete) begin
          finish  = 1'b1;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_d   = ST_GAP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response is registered so it appears in the cycle after completion.
  always_comb begin
    resp_valid_d = '0;
    resp_error_d = '0;
    resp_data_d  = resp_data_q;
    if (finish) begin
      resp_valid_d[owner_q] = 1'b1;
      resp_error_d[owner_q] = timed_out;
      resp_data_d[owner_q]  = (!timed_out && !write_q) ? data_read : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= 1'b0;
      write_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      resp_valid_q   <= '0;
      resp_error_q   <= '0;
      resp_data_q[0] <= '0;
      resp_data_q[1] <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      write_q        <= write_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_error_q   <= resp_error_d;
      resp_data_q[0] <= resp_data_d[0];
      resp_data_q[1] <= resp_data_d[1];
    end
  end

  assign command      = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? cmd_of(write_q) : CMD_IDLE;
  assign data_address = addr_q;
  assign data_write   = wdata_q;

  assign resp_valid_0 = resp_valid_q[0];
  assign resp_valid_1 = resp_valid_q[1];
  assign resp_error_0 = resp_error_q[0];
  assign resp_error_1 = resp_error_q[1];
  assign resp_data_0  = resp_data_q[0];
  assign resp_data_1  = resp_data_q[1];

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 22, request word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, completion watchdog limit (>=16).
REQ-004 SHALL have one clock, port clk, input, 1 bit; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-006 SHALL have, per client p in {0,1}: req_valid_p in 1, req_ready_p out 1, req_write_p in 1, req_address_p in ADDRESS_WIDTH, req_data_p in DATA_WIDTH.
REQ-007 SHALL have, per client p: resp_valid_p out 1, resp_data_p out DATA_WIDTH, resp_error_p out 1.
REQ-008 SHALL have controller-side outputs: command out 2, data_address out ADDRESS_WIDTH, data_write out DATA_WIDTH.
REQ-009 SHALL have controller-side inputs: data_read in DATA_WIDTH, data_read_valid in 1, data_write_done in 1.

Function
REQ-010 SHALL encode command as 2'd0 IDLE, 2'd1 WRITE, 2'd2 READ; 2'd3 never driven.
REQ-011 SHALL keep exactly one controller transaction outstanding; controller burst length 1.
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, GAP.
REQ-013 IDLE: when any req_valid_p is high, SHALL select one client round-robin, assert its req_ready_p for exactly that cycle, latch write/address/data and owner, then go to ISSUE.
REQ-014 Round-robin: after client p is granted, client 1-p SHALL have priority at the next grant; after reset client 0 has priority.
REQ-015 req_ready_p SHALL be high only in IDLE and only for the granted client; a request transfers when req_valid_p and req_ready_p are both high.
REQ-016 ISSUE/WAIT: command SHALL equal latched type and data_address/data_write latched values, held stable until completion; ISSUE lasts one cycle, then WAIT.
REQ-017 Completion SHALL be data_write_done for WRITE, data_read_valid for READ, sampled in ISSUE or WAIT; the other strobe SHALL be ignored.
REQ-018 On completion SHALL pulse resp_valid_owner for one cycle in the following cycle; resp_data_owner = data_read captured at completion (READ) or zero (WRITE); resp_error_owner low.
REQ-019 After completion SHALL enter GAP for exactly one cycle with command IDLE, then IDLE.
REQ-020 Watchdog: a cycle counter SHALL start at 0 on entry to ISSUE; if completion has not occurred when it reaches TIMEOUT_CYCLES-1, SHALL pulse resp_valid_owner with resp_error_owner high, resp_data zero, and enter GAP.
REQ-021 Completion arriving in the same cycle as the timeout SHALL be treated as completion (no error).
REQ-022 Outside ISSUE/WAIT, command SHALL be IDLE; data_address/data_write retain last values.
REQ-023 Completion strobes in IDLE or GAP SHALL be ignored.
REQ-024 Minimum request-to-request throughput per client: one transaction per (controller latency + 3) cycles.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE, command IDLE, data_address 0, data_write 0, all req_ready_p, resp_valid_p, resp_error_p low, resp_data_p 0, priority client 0, watchdog 0.
REQ-026 Reset mid-transaction SHALL abandon it with no response pulse.

Structure
REQ-027 Command encoding enum and state enum SHALL live in shared package sdram_pkg.
REQ-028 Grant selection SHALL be sub-module round_robin_arbiter (2 requesters, one-hot grant, priority update on accept).

Verification
REQ-029 Single read: client 0 READ address 22'h00ABC, controller returns data_read 16'hBEEF 5 cycles later -> resp_valid_0 one cycle after, resp_data_0 16'hBEEF, resp_error_0 0.
REQ-030 Contention: both clients valid continuously after reset -> grants alternate 0,1,0,1; no client granted twice consecutively.
REQ-031 Write: client 1 WRITE address 22'h3FFFFF data 16'h1234 -> command 2'd1 with those operands stable until data_write_done, then one GAP cycle with command 0.
REQ-032 Timeout: TIMEOUT_CYCLES=16, no completion -> resp_valid_0 with resp_error_0 high; completion on cycle 15 -> no error.
REQ-033 Reset asserted in WAIT -> outputs at reset values asynchronously; no resp_valid; next request proceeds normally.
REQ-034 Spurious data_read_valid during a WRITE or in IDLE -> no response, no state change.
